// File: rtl/gps_alert_ctrl_if.sv
// gps_alert_ctrl_if
// Byte stream from the alert sequencer to the UART transmitter.
//   tx_data  : packet byte (master -> slave)
//   tx_valid : tx_data is valid (master -> slave)
//   tx_ready : transmitter accepts the byte (slave -> master)
// A byte transfers on the clock edge where tx_valid && tx_ready.
interface gps_alert_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/gps_alert_ctrl.sv
// gps_alert_ctrl
// Panic alert sequencer: on panic_req, waits up to FIX_TIMEOUT cycles for a
// fresh GPS fix (falling back to the last-known fix, or zeros), streams an
// 11-byte packet {A5, flags, lat[31:0], lon[31:0], xor-checksum} MSB first,
// then repeats after RESEND_PERIOD idle cycles until MAX_SENDS packets.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   panic_req        : pulse, starts an alert (ignored outside IDLE)
//   cancel           : aborts the alert (latched during a packet)
//   gps_lat/gps_lon  : parser position, valid when gps_valid pulses
//   tx               : byte stream master (tx_data/tx_valid/tx_ready)
//   alert_active     : high for the whole alert
//   send_count       : packets completed in the current alert
//   done             : one-cycle pulse on normal completion
module gps_alert_ctrl #(
  parameter int FIX_TIMEOUT   = 50_000_000,
  parameter int RESEND_PERIOD = 250_000_000,
  parameter int MAX_SENDS     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               panic_req,
  input  logic               cancel,
  input  logic signed [31:0] gps_lat,
  input  logic signed [31:0] gps_lon,
  input  logic               gps_valid,
  gps_alert_ctrl_if.master   tx,
  output logic               alert_active,
  output logic [3:0]         send_count,
  output logic               done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [31:0]        timer_q, timer_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               have_fix_q, have_fix_d;
  logic               cxl_q, cxl_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         txd_q, txd_d;
  logic               txv_q, txv_d;
  logic signed [31:0] last_lat_q, last_lat_d;
  logic signed [31:0] last_lon_q, last_lon_d;
  logic signed [31:0] pkt_lat_q, pkt_lat_d;
  logic signed [31:0] pkt_lon_q, pkt_lon_d;
  logic [7:0]         flags_q, flags_d;

  logic               go;
  logic               snap_stale, snap_nofix;
  logic signed [31:0] snap_lat, snap_lon;
  logic [3:0]         cnt_inc;

  function automatic logic [7:0] fold32(input logic [31:0] x);
    return x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
  endfunction

  // Packet byte at position idx; position 10 is the xor of positions 0..9.
  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic [7:0] flags,
                                          input logic [31:0] lat, input logic [31:0] lon);
    case (idx)
      4'd0:    return 8'hA5;
      4'd1:    return flags;
      4'd2:    return lat[31:24];
      4'd3:    return lat[23:16];
      4'd4:    return lat[15:8];
      4'd5:    return lat[7:0];
      4'd6:    return lon[31:24];
      4'd7:    return lon[23:16];
      4'd8:    return lon[15:8];
      4'd9:    return lon[7:0];
      default: return 8'hA5 ^ flags ^ fold32(lat) ^ fold32(lon);
    endcase
  endfunction

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    done_d     = 1'b0;
    have_fix_d = have_fix_q;
    cxl_d      = cxl_q;
    idx_d      = idx_q;
    txd_d      = txd_q;
    txv_d      = txv_q;
    last_lat_d = last_lat_q;
    last_lon_d = last_lon_q;
    pkt_lat_d  = pkt_lat_q;
    pkt_lon_d  = pkt_lon_q;
    flags_d    = flags_q;
    go         = 1'b0;
    snap_stale = 1'b0;
    snap_nofix = 1'b0;
    snap_lat   = '0;
    snap_lon   = '0;

    if (gps_valid) begin
      last_lat_d = gps_lat;
      last_lon_d = gps_lon;
      have_fix_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (panic_req && !cancel) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          timer_d  = '0;
          active_d = 1'b1;
          cxl_d    = 1'b0;
        end
      end
      S_WAIT: begin
        if (cancel) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else if (gps_valid) begin
          // A fix arriving on the timeout cycle still counts as fresh.
          go       = 1'b1;
          snap_lat = gps_lat;
          snap_lon = gps_lon;
        end else if (timer_q == 32'(FIX_TIMEOUT - 1)) begin
          go = 1'b1;
          if (have_fix_q) begin
            snap_lat   = last_lat_q;
            snap_lon   = last_lon_q;
            snap_stale = 1'b1;
          end else begin
            snap_nofix = 1'b1;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_SEND: begin
        if (cancel) cxl_d = 1'b1;
        if (txv_q && tx.tx_ready) begin
          if (idx_q == 4'd10) begin
            txv_d   = 1'b0;
            cnt_d   = cnt_inc;
            timer_d = '0;
            // A cancel on the final handshake cycle counts as seen.
            if (cxl_q || cancel) begin
              state_d  = S_IDLE;
              active_d = 1'b0;
            end else if (cnt_inc == 4'(MAX_SENDS)) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            idx_d = idx_q + 4'd1;
            txd_d = pkt_byte(idx_q + 4'd1, flags_q, pkt_lat_q, pkt_lon_q);
          end
        end
      end
      S_GAP: begin
        if (cancel) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else if (timer_q == 32'(RESEND_PERIOD - 1)) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_FINISH: begin
        done_d   = 1'b1;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Packet start: snapshot position and flags, present the sync byte now.
    if (go) begin
      state_d   = S_SEND;
      pkt_lat_d = snap_lat;
      pkt_lon_d = snap_lon;
      flags_d   = {2'b00, cnt_q, snap_nofix, snap_stale};
      idx_d     = '0;
      txd_d     = 8'hA5;
      txv_d     = 1'b1;
      cxl_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cnt_q      <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      have_fix_q <= 1'b0;
      cxl_q      <= 1'b0;
      idx_q      <= '0;
      txd_q      <= '0;
      txv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      done_q     <= done_d;
      have_fix_q <= have_fix_d;
      cxl_q      <= cxl_d;
      idx_q      <= idx_d;
      txd_q      <= txd_d;
      txv_q      <= txv_d;
    end
  end

  // Position data carries no reset; have_fix and state qualify its use.
  always_ff @(posedge clk) begin
    last_lat_q <= last_lat_d;
    last_lon_q <= last_lon_d;
    pkt_lat_q  <= pkt_lat_d;
    pkt_lon_q  <= pkt_lon_d;
    flags_q    <= flags_d;
  end

  assign tx.tx_data   = txd_q;
  assign tx.tx_valid  = txv_q;
  assign alert_active = active_q;
  assign send_count   = cnt_q;
  assign done         = done_q;

endmodule

// File: tb/tb_gps_alert_ctrl.sv
// tb_gps_alert_ctrl
// Scoreboard bench: stimulus pushes each expected packet (built from the
// position, flags and count) into a byte queue; a monitor pops and compares
// on every tx handshake and also checks data hold under backpressure.
module tb_gps_alert_ctrl;
  localparam int FT = 16;
  localparam int RP = 8;
  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        panic_req = 1'b0;
  logic        cancel = 1'b0;
  logic        gps_valid = 1'b0;
  logic [31:0] gps_lat = '0;
  logic [31:0] gps_lon = '0;
  logic        tx_ready = 1'b1;
  logic        alert_active;
  logic [3:0]  send_count;
  logic        done;

  gps_alert_ctrl_if tx ();
  assign tx.tx_ready = tx_ready;

  gps_alert_ctrl #(.FIX_TIMEOUT(FT), .RESEND_PERIOD(RP), .MAX_SENDS(MS)) dut (
    .clk(clk), .rst(rst), .panic_req(panic_req), .cancel(cancel),
    .gps_lat(gps_lat), .gps_lon(gps_lon), .gps_valid(gps_valid), .tx(tx),
    .alert_active(alert_active), .send_count(send_count), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sb[$];
  logic [31:0] m_lat = '0;
  logic [31:0] m_lon = '0;
  bit          m_have = 1'b0;

  function automatic void push_pkt(input logic [31:0] lat, input logic [31:0] lon,
                                   input bit stale, input bit nofix, input int cnt);
    logic [7:0] b[11];
    b[0] = 8'hA5;
    b[1] = {2'b00, cnt[3:0], nofix, stale};
    for (int i = 0; i < 4; i++) begin
      b[2 + i] = 8'(lat >> (24 - 8 * i));
      b[6 + i] = 8'(lon >> (24 - 8 * i));
    end
    b[10] = 8'h00;
    for (int i = 0; i < 10; i++) b[10] = b[10] ^ b[i];
    for (int i = 0; i < 11; i++) sb.push_back(b[i]);
  endfunction

  // ---------------- monitor ----------------
  int         hs_total = 0;
  int         done_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(tx.tx_valid), 64'(1'b1));
        chk("hold_data", 64'(tx.tx_data), 64'(stall_data));
      end
      if (tx.tx_valid && tx_ready) begin
        hs_total++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h with empty queue, required no transfer (cycle %0d)",
                   tx.tx_data, cyc);
        end else begin
          mon_exp = sb.pop_front();
          chk("byte", 64'(tx.tx_data), 64'(mon_exp));
        end
      end
      stall_prev = tx.tx_valid && !tx_ready;
      stall_data = tx.tx_data;
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rnd_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse_panic();
    panic_req = 1'b1;
    tick();
    panic_req = 1'b0;
  endtask

  task automatic pulse_gps(input logic [31:0] lat, input logic [31:0] lon);
    gps_lat = lat;
    gps_lon = lon;
    gps_valid = 1'b1;
    m_lat = lat;
    m_lon = lon;
    m_have = 1'b1;
    tick();
    gps_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tx_valid", 64'(tx.tx_valid), 64'(1'b0));
    chk("rst_tx_data", 64'(tx.tx_data), 64'(8'h00));
    chk("rst_alert_active", 64'(alert_active), 64'(1'b0));
    chk("rst_send_count", 64'(send_count), 64'(4'd0));
    chk("rst_done", 64'(done), 64'(1'b0));
  endtask

  // Called at the WAIT_FIX entry edge E; returns H, the final-handshake edge.
  task automatic do_packet(input int k, input bit fresh, input int d,
                           input logic [31:0] lat, input logic [31:0] lon, input int E,
                           input bit bp, input bit cxl, output int H);
    int  base;
    int  lim;
    bit  bp_done;
    bit  cx_done;
    base = hs_total;
    if (fresh) begin
      repeat (d) tick();
      push_pkt(lat, lon, 1'b0, 1'b0, k);
      pulse_gps(lat, lon);
      chk("fresh_latency_valid", 64'(tx.tx_valid), 64'(1'b1));
      chk("fresh_first_byte", 64'(tx.tx_data), 64'(8'hA5));
    end else begin
      if (m_have) push_pkt(m_lat, m_lon, 1'b1, 1'b0, k);
      else        push_pkt(32'h0, 32'h0, 1'b0, 1'b1, k);
      lim = 0;
      while (!tx.tx_valid && lim < 200) begin
        tick();
        lim++;
      end
      chk("timeout_latency", 64'(cyc - E), 64'(FT));
    end
    lim = 0;
    bp_done = 1'b0;
    cx_done = 1'b0;
    while (hs_total < base + 11 && lim < 500) begin
      if (bp && !bp_done && hs_total == base + 2) begin
        tx_ready = 1'b0;
        repeat (5) tick();
        tx_ready = 1'b1;
        bp_done = 1'b1;
      end
      if (cxl && !cx_done && hs_total == base + 3) begin
        cancel = 1'b1;
        cx_done = 1'b1;
        tick();
        cancel = 1'b0;
      end else begin
        tick();
      end
      lim++;
    end
    chk("pkt_complete", 64'(hs_total), 64'(base + 11));
    chk("queue_drained", 64'(sb.size()), 64'(0));
    H = cyc;
  endtask

  task automatic run_alert(input bit fr0, input bit fr1, input bit gap_gps, input bit bp,
                           input int d0, input logic [31:0] lat0, input logic [31:0] lon0);
    int E;
    int H;
    int dc;
    pulse_panic();
    E = cyc;
    chk("alert_active_start", 64'(alert_active), 64'(1'b1));
    chk("send_count_start", 64'(send_count), 64'(4'd0));
    for (int k = 0; k < MS; k++) begin
      if (k == 0) do_packet(k, fr0, d0, lat0, lon0, E, bp, 1'b0, H);
      else        do_packet(k, fr1, $urandom_range(0, 10), $urandom, $urandom, E, 1'b0, 1'b0, H);
      chk("send_count_after_pkt", 64'(send_count), 64'(k + 1));
      if (k < MS - 1) begin
        chk("active_in_gap", 64'(alert_active), 64'(1'b1));
        if (gap_gps) begin
          while (cyc < H + 3) tick();
          pulse_gps($urandom, $urandom);
        end
        while (cyc < H + RP) tick();
        E = cyc;
      end
    end
    dc = done_cnt;
    chk("done_low_at_last_hs", 64'(done), 64'(1'b0));
    tick();
    chk("done_pulse", 64'(done), 64'(1'b1));
    chk("active_cleared", 64'(alert_active), 64'(1'b0));
    tick();
    chk("done_single", 64'(done), 64'(1'b0));
    chk("done_count", 64'(done_cnt - dc), 64'(1));
    chk("send_count_final", 64'(send_count), 64'(MS));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

  initial begin
    int E;
    int H;
    int h0;
    int dc;
    int base;
    int lim;

    repeat (3) tick();
    chk_reset_outputs();
    rst = 1'b0;
    tick();

    // No fix ever: zeros with no_fix flag, gap measured through the timeout.
    run_alert(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0);

    // Stale fix from before the alert.
    pulse_gps(32'h1, 32'h2);
    tick();
    run_alert(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0);

    // Fresh fix three cycles after panic; second packet fresh right at WAIT_FIX entry.
    run_alert(1'b1, 1'b1, 1'b0, 1'b0, 2, 32'h12345678, 32'h9ABCDEF0);

    // Backpressure on byte 3, stale second packet updated during the gap.
    run_alert(1'b1, 1'b0, 1'b1, 1'b1, 1, $urandom, $urandom);

    // panic with cancel in the same cycle stays idle.
    h0 = hs_total;
    panic_req = 1'b1;
    cancel = 1'b1;
    tick();
    panic_req = 1'b0;
    cancel = 1'b0;
    chk("panic_cancel_idle", 64'(alert_active), 64'(1'b0));
    repeat (FT + 4) tick();
    chk("panic_cancel_no_tx", 64'(hs_total), 64'(h0));

    // cancel while waiting for a fix.
    pulse_panic();
    repeat (4) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("wait_cancel_idle", 64'(alert_active), 64'(1'b0));
    repeat (FT + 4) tick();
    chk("wait_cancel_no_tx", 64'(hs_total), 64'(h0));

    // cancel at byte 4: packet completes, then idle with no done.
    pulse_panic();
    E = cyc;
    do_packet(0, 1'b1, 1, $urandom, $urandom, E, 1'b0, 1'b1, H);
    chk("cancel_pkt_idle", 64'(alert_active), 64'(1'b0));
    chk("cancel_pkt_count", 64'(send_count), 64'(4'd1));
    dc = done_cnt;
    h0 = hs_total;
    repeat (40) tick();
    chk("cancel_pkt_no_more_tx", 64'(hs_total), 64'(h0));
    chk("cancel_pkt_no_done", 64'(done_cnt), 64'(dc));

    // panic during WAIT_FIX ignored (timer not restarted); cancel in GAP.
    rnd_ready = 1'b1;
    pulse_panic();
    E = cyc;
    repeat (3) tick();
    pulse_panic();
    do_packet(0, 1'b0, 0, 32'h0, 32'h0, E, 1'b0, 1'b0, H);
    while (cyc < H + 3) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("gap_cancel_idle", 64'(alert_active), 64'(1'b0));
    h0 = hs_total;
    repeat (FT + RP + 4) tick();
    chk("gap_cancel_no_tx", 64'(hs_total), 64'(h0));

    // Randomized alerts with random tx_ready.
    for (int n = 0; n < 6; n++) begin
      run_alert(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b0, $urandom_range(0, 10), $urandom, $urandom);
      repeat ($urandom_range(1, 5)) tick();
    end
    rnd_ready = 1'b0;
    tx_ready = 1'b1;
    tick();

    // Reset in the middle of a packet.
    pulse_panic();
    base = hs_total;
    push_pkt(32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 1'b0, 0);
    pulse_gps(32'hCAFEF00D, 32'h0BADBEEF);
    lim = 0;
    while (hs_total < base + 5 && lim < 100) begin
      tick();
      lim++;
    end
    rst = 1'b1;
    tick();
    chk_reset_outputs();
    rst = 1'b0;
    sb.delete();
    m_have = 1'b0;
    tick();

    // After reset the last-known fix is gone: timeout gives a no-fix packet.
    pulse_panic();
    E = cyc;
    do_packet(0, 1'b0, 0, 32'h0, 32'h0, E, 1'b0, 1'b0, H);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("post_reset_cancel_idle", 64'(alert_active), 64'(1'b0));
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gps_alert_ctrl.md
# gps_alert_ctrl

Sequences a panic alert: on a panic request it waits a bounded time for a fresh fix from the GPS parser, then streams a fixed 11-byte binary alert packet to the UART transmitter over a valid/ready byte interface. It repeats the fix-and-send cycle up to a configured count, with a fixed gap between packets. It sits between the panic button logic and the parser's latitude/longitude/data_valid outputs on the input side, and the UART TX on the output side.

## Interface
- FIX_TIMEOUT, 50_000_000: cycles to wait for a fresh fix before falling back to the last-known fix; must be ≥ 2.
- RESEND_PERIOD, 250_000_000: idle cycles between the last byte of one packet and the next fix attempt; must be ≥ 1.
- MAX_SENDS, 3: packets sent per alert; range 1..15.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- panic_req  in  1  single-cycle pulse; starts an alert.
- cancel  in  1  level or pulse; aborts the alert.
- gps_lat  in  32  parser latitude.
- gps_lon  in  32  parser longitude.
- gps_valid  in  1  single-cycle pulse; gps_lat and gps_lon are valid in this cycle.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte.
- alert_active  out  1  high from alert start until return to IDLE.
- send_count  out  4  packets completed in the current alert.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- **Last-known fix register.**
  - Loaded from gps_lat/gps_lon on every gps_valid, in every state.
  - have_fix is set on the first load and cleared only by rst.
- **States:** IDLE, WAIT_FIX, SEND, GAP, FINISH.
- **IDLE**
  - panic_req with no cancel: go to WAIT_FIX, clear send_count and the timer, set alert_active.
  - panic_req with cancel in the same cycle: stay in IDLE.
- **WAIT_FIX** (the timer counts from 0)
  - gps_valid: snapshot the inputs of that same cycle, flags = fresh, go to SEND.
  - Otherwise, when timer == FIX_TIMEOUT−1:
    - have_fix set: snapshot the last-known fix, stale=1.
    - have_fix clear: snapshot zeros, no_fix=1.
    - In both cases go to SEND.
  - gps_valid and the timeout in the same cycle: gps_valid wins (fresh fix).
  - cancel: go to IDLE, no done pulse.
- **SEND.** Bytes go out in this order, MSB first:
  - 0xA5
  - flags
  - lat[31:24] .. lat[7:0]
  - lon[31:24] .. lon[7:0]
  - checksum = XOR of the previous 10 bytes.
- **flags byte:** bit0 stale, bit1 no_fix, bits5:2 = send_count before increment, bits7:6 = 0.
- **After the 11th byte is accepted**, send_count increments, then:
  - cancel seen during the packet: go to IDLE, no done.
  - send_count == MAX_SENDS: go to FINISH.
  - otherwise: go to GAP.
- **cancel during SEND** is latched. The packet is never truncated.
- **GAP.** Wait RESEND_PERIOD cycles, then enter WAIT_FIX with the timer cleared. cancel goes to IDLE.
- **FINISH.** Pulse done for 1 cycle, clear alert_active, go to IDLE.
- **panic_req outside IDLE** is ignored.

## Timing
- **Reset values:** tx_data=0, tx_valid=0, alert_active=0, send_count=0, done=0, have_fix=0, state=IDLE. rst asserted mid-packet drops tx_valid at the next edge.
- **Start latency:** panic_req sampled at edge N gives alert_active=1 after edge N.
- **Fix-to-send latency:** gps_valid sampled at edge M in WAIT_FIX gives tx_valid=1 and tx_data=0xA5 after edge M.
- **Timeout:** with no gps_valid, tx_valid rises FIX_TIMEOUT cycles after entry to WAIT_FIX.
- **Byte handshake:**
  - A byte transfers on the edge where tx_valid && tx_ready.
  - tx_data and tx_valid hold while tx_ready is low.
  - The next byte is presented in the following cycle; tx_valid stays high across bytes.
  - With tx_ready held high, a packet takes 11 cycles.
- **Gap:** WAIT_FIX is entered exactly RESEND_PERIOD cycles after the final handshake.
- **done** is high for the single cycle after the FINISH edge.

## Test plan
All scenarios use FIX_TIMEOUT=16, RESEND_PERIOD=8, MAX_SENDS=2, tx_ready=1 unless stated.
- **Fresh fix:** panic_req, then 3 cycles later gps_valid with lat=0x12345678, lon=0x9ABCDEF0 -> bytes A5,00,12,34,56,78,9A,BC,DE,F0,A5, starting 1 cycle after gps_valid.
- **No fix ever:** panic_req with no gps_valid -> 16 cycles later bytes A5,02, eight 00 bytes, A7.
- **Stale fix:** gps_valid lat=1, lon=2 before panic_req, none after -> flags=01, checksum=A7.
- **Backpressure:** tx_ready low for 5 cycles while byte 3 is presented -> tx_data held at byte 3, tx_valid stays 1, all 11 bytes arrive in order with none dropped or duplicated.
- **Repeat:** after packet 1, WAIT_FIX is entered exactly 8 cycles after the final handshake. Packet 2 has flags bits5:2=1 (0x04 with a fresh fix). done pulses once, then alert_active=0 and send_count=2.
- **Cancel and reset:**
  - cancel at byte 4 -> the packet completes, then IDLE with no done and no second packet.
  - rst mid-packet -> tx_valid=0 after the next edge and all outputs at their reset values.
